// File: rtl/unpacked_sample_fifo_pkg.sv
// Shared helpers for the unpacked sample FIFO.
// Pointer wrap and width helpers used by the FIFO and its pointers.
package unpacked_sample_fifo_pkg;

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Compare-based wrap keeps non-power-of-two depths correct.
  function automatic int unsigned ptr_inc(
    input int unsigned p,
    input int unsigned depth
  );
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/unpacked_fifo_ptr.sv
// Wrap counter with enable and clear.
// Used for both the read and the write pointer of the FIFO.
module unpacked_fifo_ptr
  import unpacked_sample_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = ptr_w(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Clear wins over advance.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = PW'(ptr_inc(32'(ptr_q), DEPTH));
    end
  end

  // Pointer register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/unpacked_sample_fifo.sv
// First-word fall-through FIFO over an unpacked storage array.
// Optional UNPACKED_SAMPLE_FIFO_SNAPSHOT_EN adds snap_data/snap_mask.
module unpacked_sample_fifo
  import unpacked_sample_fifo_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = cnt_w(DEPTH),
  localparam int unsigned PW   = ptr_w(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [W-1:0]         in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  input  logic                 out_ready,
`ifdef UNPACKED_SAMPLE_FIFO_SNAPSHOT_EN
  output logic [W*DEPTH-1:0]   snap_data,
  output logic [DEPTH-1:0]     snap_mask,
`endif
  output logic [CW-1:0]        count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rd_ptr];
  assign count     = count_q;

  unpacked_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .clr_i (flush),
    .en_i  (push),
    .ptr_o (wr_ptr)
  );

  unpacked_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .clr_i (flush),
    .en_i  (pop),
    .ptr_o (rd_ptr)
  );

  // Storage write; contents are don't-care after reset or flush.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

  // Occupancy next state; flush overrides any transfer.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Occupancy register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef UNPACKED_SAMPLE_FIFO_SNAPSHOT_EN
  int unsigned idx;

  // Rotate storage so the oldest entry lands in the low slot.
  always_comb begin
    snap_data = '0;
    snap_mask = '0;
    idx       = 0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = 32'(rd_ptr) + 32'(i);
      if (idx >= DEPTH) begin
        idx = idx - DEPTH;
      end
      snap_data[i*W +: W] = mem_q[idx[PW-1:0]];
      snap_mask[i]        = (i < int'(count_q));
    end
  end
`endif

endmodule
